// File: rtl/bcd_scan_display.sv
// bcd_scan_display: iterative double-dabble binary-to-BCD converter feeding a
// multiplexed seven-segment scanner (separator slot followed by one slot per digit,
// most significant digit first).
// Optional feature macro: LEADING_ZERO_BLANK_EN -- blanks the segments of leading
// zero digits (digit 0 is always shown).
module bcd_scan_display #(
   parameter int WIDTH    = 16,
   parameter int DIGITS   = 5,
   parameter int SCAN_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_bin,
   output logic                  bcd_valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     digit_sel
);

   // Decimal digits needed for the largest WIDTH-bit value.
   function automatic int dec_digits(input int w);
      longint unsigned v;
      int n;
      v = (64'd1 << w) - 64'd1;
      n = 0;
      while (v != 0) begin
         v = v / 10;
         n++;
      end
      return n;
   endfunction

   if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
      $error("bcd_scan_display: WIDTH must be 4..32");
   end
   if (DIGITS < dec_digits(WIDTH)) begin : g_bad_digits
      $error("bcd_scan_display: DIGITS too small for WIDTH");
   end
   if (SCAN_DIV < 1 || SCAN_DIV > 65535) begin : g_bad_div
      $error("bcd_scan_display: SCAN_DIV must be 1..65535");
   end

   localparam int CW  = $clog2(WIDTH + 1);
   localparam int SW  = $clog2(DIGITS + 1);
   localparam int DVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                state_reg, state_next;
   logic [WIDTH-1:0]      bin_reg;
   logic [4*DIGITS-1:0]   work_reg;
   logic [4*DIGITS-1:0]   work_adj;
   logic [4*DIGITS-1:0]   work_shift;
   logic [CW-1:0]         cnt_reg;
   logic [4*DIGITS-1:0]   bcd_reg;
   logic                  bcd_valid_reg;
   logic [SW-1:0]         slot_reg;
   logic [DVW-1:0]        div_reg;
   logic                  last_bit;
   logic [DIGITS-1:0]     slot_hit;
   logic [DIGITS-1:0]     blank;
   logic [6:0]            digit_seg [DIGITS];

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'h3F;
         4'd1:    seg_decode = 7'h06;
         4'd2:    seg_decode = 7'h5B;
         4'd3:    seg_decode = 7'h4F;
         4'd4:    seg_decode = 7'h66;
         4'd5:    seg_decode = 7'h6D;
         4'd6:    seg_decode = 7'h7D;
         4'd7:    seg_decode = 7'h07;
         4'd8:    seg_decode = 7'h7F;
         4'd9:    seg_decode = 7'h6F;
         default: seg_decode = 7'h00;
      endcase
   endfunction

   // Add-3 correction on every working digit that is 5 or more, one bit per cycle.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign work_adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5) ?
                                   work_reg[4*gi +: 4] + 4'd3 : work_reg[4*gi +: 4];
   end

   // The top bit shifted out is always zero because DIGITS covers the full range.
   assign work_shift = (work_adj << 1) | {{(4*DIGITS-1){1'b0}}, bin_reg[WIDTH-1]};
   assign last_bit   = (cnt_reg == CW'(1));
   assign in_ready   = (state_reg == IDLE);
   assign bcd        = bcd_reg;
   assign bcd_valid  = bcd_valid_reg;

   // Conversion state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic: accept in IDLE, leave SHIFT after the last bit.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid) state_next = SHIFT;
         SHIFT:   if (last_bit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Conversion datapath: latch operand, shift MSB first, publish the result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_reg       <= '0;
         work_reg      <= '0;
         cnt_reg       <= '0;
         bcd_reg       <= '0;
         bcd_valid_reg <= 1'b0;
      end else begin
         bcd_valid_reg <= 1'b0;
         if (state_reg == IDLE) begin
            if (in_valid) begin
               bin_reg  <= in_bin;
               work_reg <= '0;
               cnt_reg  <= CW'(WIDTH);
            end
         end else begin
            bin_reg  <= bin_reg << 1;
            work_reg <= work_shift;
            cnt_reg  <= cnt_reg - CW'(1);
            if (last_bit) begin
               bcd_reg       <= work_shift;
               bcd_valid_reg <= 1'b1;
            end
         end
      end
   end

   // Scan divider and slot counter; a fresh result restarts at the separator slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_reg <= '0;
         div_reg  <= '0;
      end else if (bcd_valid_reg) begin
         slot_reg <= '0;
         div_reg  <= '0;
      end else if (div_reg == DVW'(SCAN_DIV - 1)) begin
         div_reg  <= '0;
         slot_reg <= (slot_reg == SW'(DIGITS)) ? '0 : slot_reg + SW'(1);
      end else begin
         div_reg  <= div_reg + DVW'(1);
      end
   end

   // Slot 0 is the separator; slot s (1..DIGITS) shows digit DIGITS-s.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      localparam int SLOT = DIGITS - gi;
      assign slot_hit[gi]  = (slot_reg == SW'(SLOT));
      assign digit_seg[gi] = seg_decode(bcd_reg[4*gi +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_keep
         assign blank[gi] = 1'b0;
      end else begin : g_lz
         assign blank[gi] = (bcd_reg[4*DIGITS-1:4*gi] == '0);
      end
`else
      assign blank[gi] = 1'b0;
`endif
   end

   // Segment mux over the selected digit; separator slot shows only dp.
   always_comb begin
      seg = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (slot_hit[i] && !blank[i]) seg = seg | digit_seg[i];
      end
   end

   assign dp        = (slot_reg == '0);
   assign digit_sel = slot_hit;

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 Parameter WIDTH, default 16: binary input width in bits, 4..32.
REQ-002 Parameter DIGITS, default 5: BCD digit count; a value below ceil(log10(2^WIDTH)) SHALL be rejected at elaboration with an error.
REQ-003 Parameter SCAN_DIV, default 4: clock cycles per display slot, 1..65535.
REQ-004 Port clk  in  1: single clock; all state on posedge.
REQ-005 Port rst  in  1: asynchronous, active-high reset.
REQ-006 Port in_valid  in  1: in_bin holds a value to convert.
REQ-007 Port in_ready  out  1: block accepts a value this cycle.
REQ-008 Port in_bin  in  WIDTH: unsigned binary value.
REQ-009 Port bcd_valid  out  1: one-cycle pulse; bcd is updated with a new result.
REQ-010 Port bcd  out  4*DIGITS: last completed result; digit k in bits [4k+3:4k]; digit 0 is the ones digit.
REQ-011 Port seg  out  7: active-high segments in gfedcba order.
REQ-012 Port dp  out  1: separator / decimal-point lamp.
REQ-013 Port digit_sel  out  DIGITS: one-hot digit enable; bit k selects digit k.

Function
REQ-014 Conversion FSM states are IDLE and SHIFT; in_ready SHALL equal (state==IDLE).
REQ-015 Handshake: when in_valid&&in_ready at an edge, the block latches in_bin, clears the working BCD register, loads bit counter = WIDTH, and enters SHIFT.
REQ-016 In SHIFT, each cycle adds 3 to every working digit >=5, then shifts {digits, binary} left by one bit, MSB first.
REQ-017 Iterative double dabble: one bit per cycle, with no combinational cascade across bits.
REQ-018 On the WIDTH-th shift edge, the block writes the final value to bcd, pulses bcd_valid for exactly one cycle, and returns to IDLE.
REQ-019 Latency: handshake at edge 0 -> bcd/bcd_valid updated at edge WIDTH; in_ready is high again in that same cycle, giving a throughput of one conversion per WIDTH+1 cycles.
REQ-020 While in SHIFT, in_valid and in_bin are ignored; bcd holds the previous result.
REQ-021 Scanner: a divider counts 0..SCAN_DIV-1; slot advances on wrap.
REQ-022 Slot order is SEP, digit DIGITS-1, ..., digit 0, then back to SEP.
REQ-023 SEP slot: seg=0, dp=1, digit_sel=0.
REQ-024 Digit slot k: dp=0, digit_sel=1<<k, seg=decode(bcd digit k).
REQ-025 Decode table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; codes 10-15 decode to 00.
REQ-026 bcd_valid SHALL restart the scan: at the next edge, slot = SEP and divider = 0.
REQ-027 All outputs SHALL be registered or decoded from registers; there is no combinational path from in_* to seg, dp or digit_sel.

Reset
REQ-028 While rst is high: state=IDLE, in_ready=1, bcd=0, bcd_valid=0, slot=SEP, divider=0, seg=0, dp=1, digit_sel=0.
REQ-029 rst asserted mid-conversion aborts the conversion; no bcd_valid is produced and bcd reads 0.

Configuration
REQ-030 Macro LEADING_ZERO_BLANK_EN defined: in a digit slot, any digit more significant than the highest nonzero digit shows seg=0 while digit_sel stays asserted; digit 0 is never blanked.
REQ-031 Macro LEADING_ZERO_BLANK_EN undefined: every digit decodes per REQ-025, including leading zeros.

Verification
REQ-032 WIDTH=16, DIGITS=5: in_bin=0xFFFF handshake -> 16 cycles later bcd=0x65535, with bcd_valid high for one cycle.
REQ-033 Back-to-back: in_valid held with 1234 then 9999 -> bcd=0x01234, then bcd=0x09999, with bcd_valid pulses 17 cycles apart.
REQ-034 Reset pulse at SHIFT cycle 8 of in_bin=500 -> no bcd_valid, bcd=0, in_ready=1 after release.
REQ-035 bcd=0x00042, SCAN_DIV=4, macro undefined -> SEP for 4 cycles (seg=00, dp=1), then seg=3F,3F,3F,66,5B for 4 cycles each with digit_sel 10000..00001.
REQ-036 Same stimulus with LEADING_ZERO_BLANK_EN -> seg=00,00,00,66,5B; in_bin=0 -> only digit 0 shows 3F.
REQ-037 in_valid pulsed during SHIFT -> value ignored; result reflects only the accepted input.
